fifo_param_fc: RTL

Parametrised synchronous FIFO with flow control. It generalises the fixed 16-entry, 6-bit FIFO into configurable width and depth. It adds runtime-programmable almost-full/almost-empty thresholds, a hysteretic Pausa back-pressure output, an occupancy count, separate full/almost flags, and a clearable sticky error. It sits between a producer and a consumer; the upstream source stalls on Pausa.

---
 rtl/fifo_param_fc.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_param_fc.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, hysteretic Pausa back-pressure, occupancy count and sticky error.
module fifo_param_fc #(
  parameter int DW    = 6,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] Fifo_Data_in,
  input  logic [AW:0]   af_th,
  input  logic [AW:0]   ae_th,
  input  logic          err_clr,
  output logic [DW-1:0] Fifo_Data_out,
  output logic          Fifo_Empty,
  output logic          Fifo_Full,
  output logic          Almost_Full,
  output logic          Almost_Empty,
  output logic          Fifo_Error,
  output logic          Pausa,
  output logic [AW:0]   count
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_data_out;
  logic          r_error;
  logic          r_pausa;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_err_event;
  logic [AW:0]   w_next_count;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // push+pop on a full FIFO is accepted; pop on empty is rejected (no bypass)
  assign w_push_ok   = push & (~w_full | pop);
  assign w_pop_ok    = pop & ~w_empty;
  assign w_err_event = (push & w_full & ~pop) | (pop & w_empty);

  always_comb begin
    w_next_count = r_count;
    if (w_push_ok && !w_pop_ok)
      w_next_count = r_count + 1'b1;
    else if (!w_push_ok && w_pop_ok)
      w_next_count = r_count - 1'b1;
  end

  // Storage is intentionally left unreset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= Fifo_Data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_error    <= 1'b0;
      r_pausa    <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      r_count <= w_next_count;

      // A fresh error in the clear cycle keeps the flag set
      if (w_err_event)
        r_error <= 1'b1;
      else if (err_clr)
        r_error <= 1'b0;

      if (w_next_count >= af_th)
        r_pausa <= 1'b1;
      else if (w_next_count <= ae_th)
        r_pausa <= 1'b0;
    end
  end

  assign Fifo_Data_out = r_data_out;
  assign Fifo_Empty    = w_empty;
  assign Fifo_Full     = w_full;
  assign Almost_Full   = (r_count >= af_th);
  assign Almost_Empty  = (r_count <= ae_th);
  assign Fifo_Error    = r_error;
  assign Pausa         = r_pausa;
  assign count         = r_count;

endmodule
